// File: rtl/sha256_double_hash_sequencer_pkg.sv
// Shared types and constants for the double-SHA-256 control sequencer.
package sha_ctrl_pkg;

    localparam int ROUNDS_DEFAULT = 64;

    // Message source select for msg_load
    localparam logic MSG_SRC_HDR    = 1'b0;
    localparam logic MSG_SRC_DIGEST = 1'b1;

    // H source select for hash_init
    localparam logic H_SEL_MID = 1'b0;
    localparam logic H_SEL_IV  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD1,
        S_HASH1,
        S_ADD1,
        S_LOAD2,
        S_HASH2,
        S_ADD2,
        S_CHECK
    } seq_state_t;

endpackage

// File: rtl/sha256_double_hash_sequencer_if.sv
// Host/job and datapath control signals of the double-hash sequencer.
// master: the sequencer itself; slave: the host/datapath side.
interface sha256_double_hash_sequencer_if #(
    parameter int NONCE_W = 32,
    parameter int ROUND_W = 6
);
    logic               start;
    logic               abort;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_end;
    logic               meet_target;
    logic               busy;
    logic               hash_init;
    logic               hash_sel_iv;
    logic               msg_load;
    logic               msg_src;
    logic               round_en;
    logic [ROUND_W-1:0] round_idx;
    logic               digest_add;
    logic               check;
    logic [NONCE_W-1:0] nonce;
    logic               found;
    logic               done;

    modport master (
        input  start, abort, nonce_start, nonce_end, meet_target,
        output busy, hash_init, hash_sel_iv, msg_load, msg_src, round_en,
               round_idx, digest_add, check, nonce, found, done
    );

    modport slave (
        output start, abort, nonce_start, nonce_end, meet_target,
        input  busy, hash_init, hash_sel_iv, msg_load, msg_src, round_en,
               round_idx, digest_add, check, nonce, found, done
    );

endinterface

// File: rtl/sha256_double_hash_sequencer_round_counter.sv
// Round counter for one compression pass: counts 0..ROUNDS-1, flags the last round.
module sha_round_counter #(
    parameter int ROUNDS  = 64,
    parameter int ROUND_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    output logic [ROUND_W-1:0] idx,
    output logic               tc
);

    logic [ROUND_W-1:0] cnt_q;

    // Clear has priority so the index is already 0 on the first round of the next pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + ROUND_W'(1);
        end
    end

    assign idx = cnt_q;
    assign tc  = (cnt_q == ROUND_W'(ROUNDS - 1));

endmodule

// File: rtl/sha256_double_hash_sequencer.sv
// Control FSM for the double-SHA-256 pipeline: sequences hash 1, hash 2 and the
// target check for every nonce of a job range. Holds only control state and the nonce.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no job; waits for start
//  LOAD1   | load a..h from midstate, W from header tail + nonce
//  HASH1   | 64 rounds of the first compression
//  ADD1    | fold working vars into H (first digest)
//  LOAD2   | load a..h from standard IV, W from padded first digest
//  HASH2   | 64 rounds of the second compression
//  ADD2    | fold working vars into H (final digest)
//  CHECK   | comparator evaluates final digest; hit, last nonce or next
module sha256_double_hash_sequencer
    import sha_ctrl_pkg::*;
#(
    parameter int ROUNDS  = ROUNDS_DEFAULT,
    parameter int ROUND_W = 6,
    parameter int NONCE_W = 32
) (
    input logic                          clk,
    input logic                          reset_n,
    sha256_double_hash_sequencer_if.master bus
);

    seq_state_t         state_q, state_d;
    logic               done_d, found_d, load_job, step_nonce;
    logic               rc_clr, rc_en, rc_tc;
    logic [ROUND_W-1:0] rc_idx;
    logic [NONCE_W-1:0] nonce_q, end_q;
    logic               busy_q, init_q, sel_iv_q, src_q, round_en_q, add_q, check_q;
    logic               found_q, done_q;

    // Keep the counter cleared whenever the next cycle is not a round cycle,
    // so round_idx reads 0 outside the hash passes and restarts at 0 each pass.
    assign rc_clr = !(state_d == S_HASH1 || state_d == S_HASH2);
    assign rc_en  = (state_q == S_HASH1 || state_q == S_HASH2);

    sha_round_counter #(
        .ROUNDS  (ROUNDS),
        .ROUND_W (ROUND_W)
    ) u_round_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rc_clr),
        .en      (rc_en),
        .idx     (rc_idx),
        .tc      (rc_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort outranks everything once a job is running.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        found_d    = 1'b0;
        load_job   = 1'b0;
        step_nonce = 1'b0;
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d  = S_LOAD1;
                        load_job = 1'b1;
                    end
                end
                S_LOAD1: state_d = S_HASH1;
                S_HASH1: if (rc_tc) state_d = S_ADD1;
                S_ADD1:  state_d = S_LOAD2;
                S_LOAD2: state_d = S_HASH2;
                S_HASH2: if (rc_tc) state_d = S_ADD2;
                S_ADD2:  state_d = S_CHECK;
                S_CHECK: begin
                    if (bus.meet_target) begin
                        state_d = S_IDLE;
                        found_d = 1'b1;
                        done_d  = 1'b1;
                    end else if (nonce_q == end_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_LOAD1;
                        step_nonce = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Nonce and range end; a hit or abort leaves the nonce untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nonce_q <= '0;
            end_q   <= '0;
        end else if (load_job) begin
            nonce_q <= bus.nonce_start;
            end_q   <= bus.nonce_end;
        end else if (step_nonce) begin
            nonce_q <= nonce_q + NONCE_W'(1);
        end
    end

    // Registered strobes decoded from the next state, so each is high exactly in its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            init_q     <= 1'b0;
            sel_iv_q   <= H_SEL_MID;
            src_q      <= MSG_SRC_HDR;
            round_en_q <= 1'b0;
            add_q      <= 1'b0;
            check_q    <= 1'b0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q     <= (state_d != S_IDLE);
            init_q     <= (state_d == S_LOAD1) || (state_d == S_LOAD2);
            sel_iv_q   <= (state_d == S_LOAD2) ? H_SEL_IV : H_SEL_MID;
            src_q      <= (state_d == S_LOAD2) ? MSG_SRC_DIGEST : MSG_SRC_HDR;
            round_en_q <= (state_d == S_HASH1) || (state_d == S_HASH2);
            add_q      <= (state_d == S_ADD1) || (state_d == S_ADD2);
            check_q    <= (state_d == S_CHECK);
            found_q    <= found_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.hash_init   = init_q;
    assign bus.msg_load    = init_q;
    assign bus.hash_sel_iv = sel_iv_q;
    assign bus.msg_src     = src_q;
    assign bus.round_en    = round_en_q;
    assign bus.round_idx   = rc_idx;
    assign bus.digest_add  = add_q;
    assign bus.check       = check_q;
    assign bus.nonce       = nonce_q;
    assign bus.found       = found_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sha256_double_hash_sequencer.sv
// Self-checking bench for the double-SHA-256 control sequencer.
module tb_sha256_double_hash_sequencer;

    localparam int PASS_CYC = 133;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sha256_double_hash_sequencer_if #(.NONCE_W(32), .ROUND_W(6)) bus ();

    sha256_double_hash_sequencer #(
        .ROUNDS  (64),
        .ROUND_W (6),
        .NONCE_W (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_chk[$];
    logic [31:0] chk_obs[$];

    int tests_run = 0;
    int tests_failed = 0;
    int pcnt = 0;
    int t_acc = 0;
    int exp_idx = 0;
    int ridx_err = 0;
    int strobe_err = 0;
    int round_cnt = 0;

    logic        obs_ok;
    logic        obs_found;
    logic [31:0] obs_nonce;
    int          obs_lat;

    // Free-running edge counter used for latency measurement.
    always @(posedge clk) pcnt++;

    // Protocol monitor: records checked nonces, tracks round_idx sweeps and strobe exclusivity.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_idx = 0;
        end else begin
            if (bus.check) chk_obs.push_back(bus.nonce);
            if (bus.round_en) begin
                round_cnt++;
                if (bus.round_idx !== 6'(exp_idx)) ridx_err++;
                exp_idx++;
            end else begin
                if (exp_idx != 0 && exp_idx != 64 && !bus.done) ridx_err++;
                if (bus.round_idx !== 6'd0) ridx_err++;
                exp_idx = 0;
            end
            if ($countones({bus.hash_init, bus.round_en, bus.digest_add, bus.check}) > 1) strobe_err++;
            if (bus.msg_load !== bus.hash_init) strobe_err++;
            if (bus.hash_sel_iv !== bus.msg_src) strobe_err++;
            if (bus.hash_sel_iv && !bus.hash_init) strobe_err++;
            if (!bus.busy && (bus.hash_init || bus.round_en || bus.digest_add || bus.check)) strobe_err++;
            if (bus.found && !bus.done) strobe_err++;
            if (bus.done && bus.busy) strobe_err++;
        end
    end

    function automatic logic [47:0] all_outputs();
        return {bus.busy, bus.hash_init, bus.hash_sel_iv, bus.msg_load, bus.msg_src,
                bus.round_en, bus.digest_add, bus.check, bus.found, bus.done,
                bus.round_idx, bus.nonce};
    endfunction

    function automatic logic seq_matches();
        if (chk_obs.size() != exp_chk.size()) return 1'b0;
        foreach (exp_chk[i]) if (chk_obs[i] !== exp_chk[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: walks the range and predicts the checked nonces and the outcome.
    task automatic push_expect(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] hit, input logic hit_en);
        logic [31:0] n;
        int cnt;
        exp_t x;
        n = s;
        cnt = 0;
        exp_chk.delete();
        x.found = 1'b0;
        while (cnt < 1000) begin
            exp_chk.push_back(n);
            cnt++;
            if (hit_en && n == hit) begin
                x.found = 1'b1;
                break;
            end
            if (n == e) break;
            n = n + 32'd1;
        end
        x.nonce = n;
        x.lat = cnt * PASS_CYC;
        exp_q.push_back(x);
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        chk_obs.delete();
        bus.nonce_start = s;
        bus.nonce_end = e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t_acc = pcnt;
    endtask

    task automatic wait_done(input int budget, input logic [31:0] hit, input logic hit_en);
        obs_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.meet_target = hit_en && bus.check && (bus.nonce == hit);
            if (bus.done) begin
                obs_ok = 1'b1;
                obs_found = bus.found;
                obs_nonce = bus.nonce;
                obs_lat = pcnt - t_acc;
                break;
            end
        end
        bus.meet_target = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_outputs() !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", all_outputs());
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_single();
        exp_t x;
        push_expect(32'h10, 32'h10, 32'h0, 1'b0);
        start_job(32'h10, 32'h10);
        wait_done(300, 32'h0, 1'b0);
        x = exp_q.pop_front();
        tests_run++;
        if (obs_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_timeout: no done pulse, required done within 300 cycles");
        end
        tests_run++;
        if (obs_found !== x.found) begin
            tests_failed++;
            $display("FAIL single_found: got %b required %b", obs_found, x.found);
        end
        tests_run++;
        if (obs_nonce !== x.nonce) begin
            tests_failed++;
            $display("FAIL single_nonce: got %h required %h", obs_nonce, x.nonce);
        end
        tests_run++;
        if (obs_lat != x.lat) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d required %0d", obs_lat, x.lat);
        end
        tests_run++;
        if (seq_matches() !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_check_seq: got %0d checks required %0d", chk_obs.size(), exp_chk.size());
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_after: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_hit();
        exp_t x;
        push_expect(32'h0, 32'hFF, 32'h3, 1'b1);
        round_cnt = 0;
        start_job(32'h0, 32'hFF);
        wait_done(700, 32'h3, 1'b1);
        x = exp_q.pop_front();
        tests_run++;
        if (obs_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL hit_timeout: no done pulse, required done within 700 cycles");
        end
        tests_run++;
        if (obs_found !== x.found) begin
            tests_failed++;
            $display("FAIL hit_found: got %b required %b", obs_found, x.found);
        end
        tests_run++;
        if (obs_nonce !== x.nonce) begin
            tests_failed++;
            $display("FAIL hit_nonce: got %h required %h", obs_nonce, x.nonce);
        end
        tests_run++;
        if (obs_lat != x.lat) begin
            tests_failed++;
            $display("FAIL hit_latency: got %0d required %0d", obs_lat, x.lat);
        end
        tests_run++;
        if (seq_matches() !== 1'b1) begin
            tests_failed++;
            $display("FAIL hit_check_seq: got %0d checks required %0d", chk_obs.size(), exp_chk.size());
        end
        tests_run++;
        if (round_cnt != 4 * 128) begin
            tests_failed++;
            $display("FAIL hit_round_cycles: got %0d required %0d", round_cnt, 4 * 128);
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        push_expect(32'hFFFF_FFFE, 32'h1, 32'h0, 1'b0);
        start_job(32'hFFFF_FFFE, 32'h1);
        wait_done(700, 32'h0, 1'b0);
        x = exp_q.pop_front();
        tests_run++;
        if (obs_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_timeout: no done pulse, required done within 700 cycles");
        end
        tests_run++;
        if (obs_found !== x.found || obs_nonce !== x.nonce) begin
            tests_failed++;
            $display("FAIL wrap_result: got found=%b nonce=%h required found=%b nonce=%h",
                     obs_found, obs_nonce, x.found, x.nonce);
        end
        tests_run++;
        if (obs_lat != x.lat) begin
            tests_failed++;
            $display("FAIL wrap_latency: got %0d required %0d", obs_lat, x.lat);
        end
        tests_run++;
        if (seq_matches() !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_check_seq: got %0d checks required %0d", chk_obs.size(), exp_chk.size());
        end
    endtask

    task automatic test_abort();
        exp_t x;
        logic reached;
        logic any_activity;
        x.found = 1'b0;
        x.nonce = 32'h0;
        x.lat = 88;
        exp_q.push_back(x);
        start_job(32'h0, 32'h5);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pcnt - t_acc == 87) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (reached !== 1'b1 || {bus.round_en, bus.round_idx} !== {1'b1, 6'd20}) begin
            tests_failed++;
            $display("FAIL abort_position: got round_en=%b round_idx=%0d required 1 20",
                     bus.round_en, bus.round_idx);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        x = exp_q.pop_front();
        tests_run++;
        if (bus.done !== 1'b1 || bus.found !== x.found || (pcnt - t_acc) != x.lat) begin
            tests_failed++;
            $display("FAIL abort_done: got done=%b found=%b at %0d required 1 %b at %0d",
                     bus.done, bus.found, pcnt - t_acc, x.found, x.lat);
        end
        tests_run++;
        if ({bus.busy, bus.hash_init, bus.round_en, bus.digest_add, bus.check, bus.round_idx} !== 11'h0) begin
            tests_failed++;
            $display("FAIL abort_strobes: got busy=%b init=%b round_en=%b add=%b check=%b idx=%0d required all 0",
                     bus.busy, bus.hash_init, bus.round_en, bus.digest_add, bus.check, bus.round_idx);
        end
        tests_run++;
        if (bus.nonce !== x.nonce) begin
            tests_failed++;
            $display("FAIL abort_nonce: got %h required %h", bus.nonce, x.nonce);
        end
        any_activity = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_activity |= bus.busy | bus.done | bus.hash_init | bus.round_en | bus.check;
        end
        tests_run++;
        if (any_activity !== 1'b0 || chk_obs.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got activity=%b checks=%0d required 0 0", any_activity, chk_obs.size());
        end
    endtask

    task automatic test_ignored();
        exp_t x;
        logic any_activity;
        push_expect(32'h20, 32'h21, 32'h0, 1'b0);
        start_job(32'h20, 32'h21);
        repeat (10) @(negedge clk);
        bus.nonce_start = 32'h99;
        bus.nonce_end = 32'h99;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(400, 32'h0, 1'b0);
        x = exp_q.pop_front();
        tests_run++;
        if (obs_ok !== 1'b1 || obs_nonce !== x.nonce || obs_found !== x.found) begin
            tests_failed++;
            $display("FAIL busy_start_result: got ok=%b nonce=%h found=%b required 1 %h %b",
                     obs_ok, obs_nonce, obs_found, x.nonce, x.found);
        end
        tests_run++;
        if (obs_lat != x.lat) begin
            tests_failed++;
            $display("FAIL busy_start_latency: got %0d required %0d", obs_lat, x.lat);
        end
        tests_run++;
        if (seq_matches() !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_check_seq: got %0d checks required %0d", chk_obs.size(), exp_chk.size());
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        any_activity = bus.busy | bus.done | bus.hash_init;
        @(negedge clk);
        any_activity |= bus.busy | bus.done | bus.hash_init;
        bus.abort = 1'b0;
        @(negedge clk);
        any_activity |= bus.busy | bus.done | bus.hash_init;
        @(negedge clk);
        any_activity |= bus.busy | bus.done | bus.hash_init;
        tests_run++;
        if (any_activity !== 1'b0 || bus.nonce !== 32'h21) begin
            tests_failed++;
            $display("FAIL idle_start_abort: got activity=%b nonce=%h required 0 00000021",
                     any_activity, bus.nonce);
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        logic reached;
        start_job(32'h40, 32'h50);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pcnt - t_acc == 30) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (reached !== 1'b1 || bus.round_en !== 1'b1 || bus.round_idx !== 6'd29) begin
            tests_failed++;
            $display("FAIL reset_mid_position: got round_en=%b idx=%0d required 1 29", bus.round_en, bus.round_idx);
        end
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (all_outputs() !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %h required 0", all_outputs());
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (all_outputs() !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got %h required 0", all_outputs());
        end
        reset_n = 1'b1;
        push_expect(32'h7, 32'h7, 32'h0, 1'b0);
        start_job(32'h7, 32'h7);
        wait_done(300, 32'h0, 1'b0);
        x = exp_q.pop_front();
        tests_run++;
        if (obs_ok !== 1'b1 || obs_nonce !== x.nonce || obs_found !== x.found || obs_lat != x.lat) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got ok=%b nonce=%h found=%b lat=%0d required 1 %h %b %0d",
                     obs_ok, obs_nonce, obs_found, obs_lat, x.nonce, x.found, x.lat);
        end
        tests_run++;
        if (seq_matches() !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_check_seq: got %0d checks required %0d", chk_obs.size(), exp_chk.size());
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (ridx_err != 0) begin
            tests_failed++;
            $display("FAIL round_idx_sweep: got %0d violations required 0", ridx_err);
        end
        tests_run++;
        if (strobe_err != 0) begin
            tests_failed++;
            $display("FAIL strobe_exclusive: got %0d violations required 0", strobe_err);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.nonce_start = 32'h0;
        bus.nonce_end = 32'h0;
        bus.meet_target = 1'b0;
        test_reset();
        test_single();
        test_hit();
        test_wrap();
        test_abort();
        test_ignored();
        test_reset_mid();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule
